uart_rx: RTL



---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_sync.sv | 35 +++
 rtl/uart_rx.sv | 109 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default line constants
// used by both uart_rx and uart_tx.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_e;

    localparam logic [31:0] UART_CLOCK_FREQ = 32'd50000000;
    localparam logic [31:0] UART_BAUDRATE   = 32'd115200;
    localparam logic [31:0] UART_BAUD_DIV   = UART_CLOCK_FREQ / UART_BAUDRATE;
    localparam int          UART_DATA_BITS  = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial input plus a falling-edge detector
// that only fires after a real high level has been seen on the line.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic fall
);

    logic       s1;
    logic       s2;
    logic       d;
    logic [2:0] fill;

    // fill[2] marks that d holds a sampled line value rather than the reset 1,
    // so a line held low through reset is never mistaken for a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            d    <= 1'b1;
            fill <= 3'b000;
        end else begin
            s1   <= din;
            s2   <= s1;
            d    <= s2;
            fill <= {fill[1:0], 1'b1};
        end
    end

    assign dout = s2;
    assign fall = fill[2] & d & ~s2;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, start-glitch rejection, framing-error flag.
// rx_done is a valid-only strobe with no ready: rx_data is valid in that cycle and holds until the next good frame.
module uart_rx
    import uart_pkg::*;
#(
    parameter logic [31:0] CLOCK_FREQ = UART_CLOCK_FREQ,
    parameter logic [31:0] BAUDRATE   = UART_BAUDRATE,
    parameter logic [31:0] BAUD_DIV   = CLOCK_FREQ / BAUDRATE,
    parameter logic [31:0] HALF_DIV   = BAUD_DIV / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_rxd,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam logic [15:0] BIT_LAST  = 16'(BAUD_DIV - 32'd1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_DIV - 32'd1);

    uart_rx_state_e             state;
    logic [15:0]                baud_cnt;
    logic [2:0]                 bit_cnt;
    logic [UART_DATA_BITS-1:0]  shift;
    logic                       rxd_s;
    logic                       rxd_fall;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (serial_rxd),
        .dout (rxd_s),
        .fall (rxd_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= 16'd0;
            bit_cnt   <= 3'd0;
            shift     <= '0;
            rx_data   <= 8'h00;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    baud_cnt <= 16'd0;
                    if (rxd_fall) begin
                        state   <= START;
                        rx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= 16'd0;
                        if (!rxd_s) begin
                            state <= DATA;
                        end else begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= 16'd0;
                        shift    <= {rxd_s, shift[UART_DATA_BITS-1:1]};
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    // Leave at the stop-bit midpoint so a zero-idle next start edge is caught.
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= 16'd0;
                        state    <= IDLE;
                        rx_busy  <= 1'b0;
                        if (rxd_s) begin
                            rx_data <= shift;
                            rx_done <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    baud_cnt <= 16'd0;
                    rx_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
